// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD down timer.
// Holds the FSM state encoding and the per-digit BCD limits.
package bcd_timer_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer.
// Chained through borrow_in/borrow_out to form a multi-digit down counter.
module bcd_digit_dec
   import bcd_timer_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] digit_next,
   output logic               borrow_out
);

   always_comb begin
      digit_next = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == '0) begin
            digit_next = BCD_MAX;
            borrow_out = 1'b1;
         end else begin
            digit_next = digit - 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load, start, pause and a DONE pulse.
// Define BCD_DOWN_TIMER_RELOAD_EN to auto-reload the stored preset on completion.
module bcd_down_timer
   import bcd_timer_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int TICK_DIV = 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      LOAD,
   input  logic [DIGIT_W*DIGITS-1:0] LOAD_VAL,
   input  logic                      START,
   input  logic                      PAUSE,
   output logic [DIGIT_W*DIGITS-1:0] OUT,
   output logic                      BUSY,
   output logic                      DONE,
   output logic                      ERR
);

   localparam int CW = DIGIT_W * DIGITS;
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   state_t            state_q, state_n;
   logic [CW-1:0]     count_q, count_n;
   logic [CW-1:0]     preset_q, preset_n;
   logic [TICK_W-1:0] tick_q, tick_n;
   logic              err_q, err_n;

   logic [CW-1:0]     clamped;
   logic [DIGITS-1:0] digit_bad;
   logic [CW-1:0]     dec_val;
   logic [DIGITS:0]   borrow;

   // Out-of-range load digits saturate to 9 rather than being dropped.
   for (genvar i = 0; i < DIGITS; i++) begin : g_clamp
      assign digit_bad[i] = LOAD_VAL[i*DIGIT_W +: DIGIT_W] > BCD_MAX;
      assign clamped[i*DIGIT_W +: DIGIT_W] =
         digit_bad[i] ? BCD_MAX : LOAD_VAL[i*DIGIT_W +: DIGIT_W];
   end

   assign borrow[0] = 1'b1;
   for (genvar i = 0; i < DIGITS; i++) begin : g_dec
      bcd_digit_dec u_dec (
         .digit      (count_q[i*DIGIT_W +: DIGIT_W]),
         .borrow_in  (borrow[i]),
         .digit_next (dec_val[i*DIGIT_W +: DIGIT_W]),
         .borrow_out (borrow[i+1])
      );
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         count_q  <= '0;
         preset_q <= '0;
         tick_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         count_q  <= count_n;
         preset_q <= preset_n;
         tick_q   <= tick_n;
         err_q    <= err_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      count_n  = count_q;
      preset_n = preset_q;
      tick_n   = tick_q;
      err_n    = err_q;
      if (LOAD) begin
         count_n  = clamped;
         preset_n = clamped;
         state_n  = IDLE;
         tick_n   = '0;
         err_n    = |digit_bad;
      end else begin
         case (state_q)
            IDLE: begin
               if (START) begin
                  tick_n  = '0;
                  state_n = (count_q != '0) ? RUN : FINISH;
               end
            end
            RUN: begin
               if (PAUSE) begin
                  state_n = PAUSED;
               end else if (tick_q == TICK_LAST) begin
                  tick_n = '0;
                  // A borrow out of the top digit means we were already at zero;
                  // hold zero instead of wrapping to all nines.
                  count_n = borrow[DIGITS] ? '0 : dec_val;
                  if (borrow[DIGITS] || dec_val == '0)
                     state_n = FINISH;
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
            PAUSED: begin
               if (START && !PAUSE)
                  state_n = RUN;
            end
            FINISH: begin
               state_n = IDLE;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
               if (preset_q != '0) begin
                  count_n = preset_q;
                  tick_n  = '0;
                  state_n = RUN;
               end
`endif
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign OUT  = count_q;
   assign DONE = (state_q == FINISH);
   assign ERR  = err_q;
`ifdef BCD_DOWN_TIMER_RELOAD_EN
   assign BUSY = (state_q == RUN) || (state_q == PAUSED) ||
                 ((state_q == FINISH) && (preset_q != '0));
`else
   assign BUSY = (state_q == RUN) || (state_q == PAUSED);
`endif

endmodule
